// File: rtl/fc_rx_crc_check_pkg.sv
// rtl/fc_rx_crc_check_pkg.sv - shared constants, error-bit indices and FSM state type for the FC RX CRC checker
package fc_rx_crc_check_pkg;

  typedef logic [31:0] crc32_residue_t;

  localparam crc32_residue_t CRC32_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0]    CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]    CRC32_POLY    = 32'h04C1_1DB7;

  localparam int ERR_CRC   = 0;
  localparam int ERR_RUNT  = 1;
  localparam int ERR_ABORT = 2;

  // 6 header words + CRC + EOF primitive
  localparam int MIN_FRAME_WORDS = 8;
  localparam int FILL_WORDS      = 2;

  localparam logic [31:0] MM_UNMAPPED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } crc_state_t;

endpackage

// File: rtl/fc_crc32_d32.sv
// rtl/fc_crc32_d32.sv - combinational CRC-32 update for one 32-bit word, MSB first, non-reflected
module fc_crc32_d32
  import fc_rx_crc_check_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [31:0] crc_i,
  output logic [31:0] crc_o
);

  logic [31:0] r;

  always_comb begin
    r = crc_i;
    for (int i = 31; i >= 0; i--) begin
      if (r[31] ^ data_i[i]) begin
        r = {r[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        r = {r[30:0], 1'b0};
      end
    end
    crc_o = r;
  end

endmodule

// File: rtl/fc_rx_crc_check.sv
// rtl/fc_rx_crc_check.sv - strips SOF/EOF/CRC from the FC RX stream, checks CRC-32, tags errors on eop.
// Frame counters and the full status map are built only with FC_RX_CRC_STATS_EN.
module fc_rx_crc_check
  import fc_rx_crc_check_pkg::*;
#(
  parameter int MTU = 3072
) (
  input  logic        rx_clk,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [1:0]  out_empty,
  output logic [2:0]  out_error,
  input  logic [2:0]  mm_address,
  input  logic        mm_read,
  output logic [31:0] mm_readdata
);

  localparam int CMAX = MTU / 4;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] C_MAX = CW'(CMAX);

  crc_state_t    state_q;
  logic [CW-1:0] c_q;
  logic [31:0]   crc_q;
  logic [31:0]   s0_q;
  logic [31:0]   s1_q;
  logic [31:0]   out_data_q;
  logic          out_valid_q;
  logic          out_sop_q;
  logic          out_eop_q;
  logic [2:0]    out_error_q;
  logic [31:0]   rd_q;
  logic [31:0]   rd_d;

  logic [31:0]   crc_next;
  logic [CW-1:0] c_inc;
  logic          in_frame;
  logic          beat_sof;
  logic          beat_eof;
  logic          beat_dat;
  logic          crc_bad;
  logic          runt_word;
  logic [2:0]    eof_err;
  logic [2:0]    abort_err;

  fc_crc32_d32 u_crc32 (
    .data_i (in_data),
    .crc_i  (crc_q),
    .crc_o  (crc_next)
  );

  // A beat carrying both sop and eop is a lone primitive and matches none of these.
  assign beat_sof = in_valid &  in_startofpacket & ~in_endofpacket;
  assign beat_eof = in_valid & ~in_startofpacket &  in_endofpacket;
  assign beat_dat = in_valid & ~in_startofpacket & ~in_endofpacket;
  assign in_frame = (state_q != IDLE);
  assign c_inc    = (c_q == C_MAX) ? c_q : c_q + 1'b1;

  always_comb begin
    crc_bad   = (crc_q != CRC32_RESIDUE);
    runt_word = (c_inc < CW'(MIN_FRAME_WORDS));
    eof_err   = '0;
    eof_err[ERR_CRC]  = crc_bad;
    eof_err[ERR_RUNT] = runt_word;
    abort_err = '0;
    abort_err[ERR_ABORT] = 1'b1;
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      c_q         <= '0;
      crc_q       <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_error_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_error_q <= '0;
      if (beat_sof) begin
        if (state_q == STREAM) begin
          out_valid_q <= 1'b1;
          out_data_q  <= s1_q;
          out_sop_q   <= (c_q == CW'(FILL_WORDS));
          out_eop_q   <= 1'b1;
          out_error_q <= abort_err;
        end
        state_q <= FILL;
        c_q     <= '0;
        crc_q   <= CRC32_INIT;
        s0_q    <= '0;
        s1_q    <= '0;
      end else if (in_frame && (beat_dat || beat_eof)) begin
        c_q  <= c_inc;
        s0_q <= in_data;
        s1_q <= s0_q;
        if (state_q == STREAM) begin
          out_valid_q <= 1'b1;
          out_data_q  <= s1_q;
          out_sop_q   <= (c_q == CW'(FILL_WORDS));
        end
        if (beat_eof) begin
          // The CRC word is already folded; the EOF primitive itself never is.
          if (state_q == STREAM) begin
            out_eop_q   <= 1'b1;
            out_error_q <= eof_err;
          end
          state_q <= IDLE;
        end else begin
          crc_q <= crc_next;
          if (c_inc == CW'(FILL_WORDS)) begin
            state_q <= STREAM;
          end
        end
      end
    end
  end

`ifdef FC_RX_CRC_STATS_EN
  logic [31:0] cnt_good_q;
  logic [31:0] cnt_crc_q;
  logic [31:0] cnt_runt_q;
  logic [31:0] cnt_abort_q;
  logic        ev_good;
  logic        ev_crc;
  logic        ev_runt;
  logic        ev_abort;

  always_comb begin
    ev_good  = 1'b0;
    ev_crc   = 1'b0;
    ev_runt  = 1'b0;
    ev_abort = in_frame && beat_sof;
    if (in_frame && beat_eof) begin
      if (state_q != STREAM) begin
        ev_runt = 1'b1;
      end else begin
        ev_crc  = crc_bad;
        ev_runt = runt_word;
        ev_good = !crc_bad && !runt_word;
      end
    end
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_good_q  <= '0;
      cnt_crc_q   <= '0;
      cnt_runt_q  <= '0;
      cnt_abort_q <= '0;
    end else begin
      if (ev_good)  cnt_good_q  <= cnt_good_q + 1'b1;
      if (ev_crc)   cnt_crc_q   <= cnt_crc_q + 1'b1;
      if (ev_runt)  cnt_runt_q  <= cnt_runt_q + 1'b1;
      if (ev_abort) cnt_abort_q <= cnt_abort_q + 1'b1;
    end
  end
`endif

  always_comb begin
    rd_d = MM_UNMAPPED;
    case (mm_address)
`ifdef FC_RX_CRC_STATS_EN
      3'd0:    rd_d = cnt_good_q;
      3'd1:    rd_d = cnt_crc_q;
      3'd2:    rd_d = cnt_runt_q;
      3'd3:    rd_d = cnt_abort_q;
`endif
      3'd4:    rd_d = 32'(state_q);
      default: rd_d = MM_UNMAPPED;
    endcase
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else if (mm_read) begin
      rd_q <= rd_d;
    end
  end

  assign out_data          = out_data_q;
  assign out_valid         = out_valid_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_error         = out_error_q;
  assign out_empty         = 2'b00;
  assign mm_readdata       = rd_q;

endmodule

// File: tb/tb_fc_rx_crc_check.sv
// tb/tb_fc_rx_crc_check.sv - scoreboard bench for fc_rx_crc_check
module tb_fc_rx_crc_check;

  logic        rx_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_startofpacket = 1'b0;
  logic        in_endofpacket = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;
  logic [2:0]  out_error;
  logic [2:0]  mm_address = '0;
  logic        mm_read = 1'b0;
  logic [31:0] mm_readdata;

  fc_rx_crc_check #(.MTU(3072)) dut (
    .rx_clk            (rx_clk),
    .reset_n           (reset_n),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .out_error         (out_error),
    .mm_address        (mm_address),
    .mm_read           (mm_read),
    .mm_readdata       (mm_readdata)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_good = 0, n_crc = 0, n_runt = 0, n_abort = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge rx_clk) begin : monitor
    exp_t e;
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data", out_data, e.d);
        check("sop", 32'(out_startofpacket), 32'(e.sop));
        check("eop", 32'(out_endofpacket), 32'(e.eop));
        check("empty", 32'(out_empty), 32'd0);
        if (e.eop) check("error", 32'(out_error), 32'(e.err));
      end
    end
  end

  function automatic logic [31:0] crc_of(input logic [31:0] w[$]);
    logic [31:0] r;
    logic        fb;
    r = 32'hFFFF_FFFF;
    foreach (w[i]) begin
      for (int b = 31; b >= 0; b--) begin
        fb = r[31] ^ w[i][b];
        r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
      end
    end
    return r;
  endfunction

  task automatic beat(input logic [31:0] d, input logic sop, input logic eop, input int gap);
    @(negedge rx_clk);
    in_valid = 1'b1;
    in_data = d;
    in_startofpacket = sop;
    in_endofpacket = eop;
    repeat (gap) begin
      @(negedge rx_clk);
      in_valid = 1'b0;
      in_data = $urandom;
      in_startofpacket = 1'($urandom_range(0, 1));
      in_endofpacket = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge rx_clk);
      in_valid = 1'b0;
      in_startofpacket = 1'b0;
      in_endofpacket = 1'b0;
    end
  endtask

  function automatic int pick_gap(input int maxgap);
    return (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0;
  endfunction

  // Words after SOF (CRC word last when end_eof). Frame ends on EOF, or is aborted by the caller's next SOF.
  task automatic frame(input logic [31:0] w[$], input bit end_eof, input int maxgap, input bit prim);
    int n;
    int c;
    bit bad;
    bit runt;
    exp_t e;
    n = w.size();
    c = end_eof ? n + 1 : n;
    bad = (crc_of(w) != 32'hC704_DD7B);
    runt = (c < 8);
    if (n >= 2) begin
      for (int k = 0; k <= n - 2; k++) begin
        e.d = w[k];
        e.sop = (k == 0);
        e.eop = (k == n - 2);
        e.err = end_eof ? {1'b0, runt, bad} : 3'b100;
        exp_q.push_back(e);
      end
    end
    if (!end_eof) n_abort++;
    else if (n < 2) n_runt++;
    else begin
      if (bad) n_crc++;
      if (runt) n_runt++;
      if (!bad && !runt) n_good++;
    end
    beat($urandom, 1'b1, 1'b0, pick_gap(maxgap));
    for (int k = 0; k < n; k++) begin
      beat(w[k], 1'b0, 1'b0, pick_gap(maxgap));
      if (prim && k == 2) beat(32'hFFFF_FFFF, 1'b1, 1'b1, pick_gap(maxgap));
    end
    if (end_eof) begin
      beat($urandom, 1'b0, 1'b1, pick_gap(maxgap));
      idle(3);
    end
  endtask

  task automatic mm_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(negedge rx_clk);
    mm_address = a;
    mm_read = 1'b1;
    @(negedge rx_clk);
    mm_read = 1'b0;
    check(tag, mm_readdata, exp);
  endtask

  task automatic check_counters();
`ifdef FC_RX_CRC_STATS_EN
    mm_check(3'd0, 32'(n_good), "cnt_good");
    mm_check(3'd1, 32'(n_crc), "cnt_crc");
    mm_check(3'd2, 32'(n_runt), "cnt_runt");
    mm_check(3'd3, 32'(n_abort), "cnt_abort");
`else
    mm_check(3'd0, 32'hFFFF_FFFF, "mm_addr0_nostats");
    mm_check(3'd3, 32'hFFFF_FFFF, "mm_addr3_nostats");
`endif
    mm_check(3'd4, 32'd0, "state_idle");
    mm_check(3'd7, 32'hFFFF_FFFF, "mm_addr7");
  endtask

  logic [31:0] fw[$];
  logic [31:0] bw[$];
  logic [31:0] rw[$];
  logic [31:0] sw[$];
  logic [31:0] aw[$];
  logic [31:0] gw[$];
  exp_t er;

  initial begin
    for (int i = 1; i <= 6; i++) fw.push_back(32'(i));
    fw.push_back(32'hDEAD_BEEF);
    fw.push_back(~crc_of(fw));
    bw = fw;
    bw[6] = bw[6] ^ 32'h0000_0100;
    rw.push_back(32'hA1); rw.push_back(32'hA2); rw.push_back(32'hA3);
    rw.push_back(~crc_of(rw));
    sw.push_back(32'h55);
    for (int i = 0; i < 5; i++) aw.push_back(32'h10 + 32'(i));
    for (int i = 1; i <= 6; i++) gw.push_back(32'h100 + 32'(i));
    gw.push_back(32'hCAFE_0001); gw.push_back(32'hCAFE_0002);
    gw.push_back(~crc_of(gw));

    repeat (3) @(negedge rx_clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_eop", 32'(out_endofpacket), 32'd0);
    check("rst_rd", mm_readdata, 32'd0);
    reset_n = 1'b1;
    idle(2);

    beat(32'h9, 1'b0, 1'b0, 0);
    beat(32'hA, 1'b0, 1'b1, 0);
    beat(32'hB, 1'b1, 1'b1, 0);
    idle(3);

    frame(fw, 1'b1, 0, 1'b0);
    frame(bw, 1'b1, 0, 1'b0);
    frame(rw, 1'b1, 0, 1'b0);
    frame(sw, 1'b1, 0, 1'b0);
    frame(aw, 1'b0, 0, 1'b0);
    frame(gw, 1'b1, 0, 1'b0);
    frame(sw, 1'b0, 0, 1'b0);
    frame(fw, 1'b1, 0, 1'b0);
    frame(fw, 1'b1, 3, 1'b1);
    idle(2);
    check("drain1", 32'(exp_q.size()), 32'd0);
    check_counters();

    for (int i = 1; i <= 3; i++) begin
      er.d = 32'h20 + 32'(i); er.sop = (i == 1); er.eop = 1'b0; er.err = 3'b000;
      exp_q.push_back(er);
    end
    beat(32'h0, 1'b1, 1'b0, 0);
    beat(32'h21, 1'b0, 1'b0, 0);
    idle(1);
    mm_check(3'd4, 32'd1, "state_fill");
    for (int i = 2; i <= 5; i++) beat(32'h20 + 32'(i), 1'b0, 1'b0, 0);
    idle(1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_sop", 32'(out_startofpacket), 32'd0);
    check("mid_rst_error", 32'(out_error), 32'd0);
    check("mid_rst_rd", mm_readdata, 32'd0);
    n_good = 0; n_crc = 0; n_runt = 0; n_abort = 0;
    repeat (2) @(negedge rx_clk);
    reset_n = 1'b1;
    idle(2);

    frame(gw, 1'b1, 2, 1'b0);
    idle(2);
    check("drain2", 32'(exp_q.size()), 32'd0);
    check_counters();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
